regfile_sb_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_scoreboard.sv | 50 +++++
 rtl/regfile_sb_mp.sv | 69 ++++++
 tb/tb_regfile_sb_mp.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, address-width helper and write-request type for the register file
package regfile_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_NR = 2;
    localparam int DEF_NW = 1;

    function automatic int calc_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int DEF_AW = calc_aw(DEF_DEPTH);

    typedef struct packed {
        logic                 en;
        logic [DEF_AW-1:0]    addr;
        logic [DEF_WIDTH-1:0] data;
    } wr_req_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy vector with write-clear, reserve, flush priority and a registered popcount
module regfile_scoreboard import regfile_pkg::*; #(
    parameter int DEPTH = DEF_DEPTH,
    parameter int NW = DEF_NW,
    parameter int ZERO_REG = 1,
    localparam int AW = calc_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NW-1:0]    wr_eff,
    input  logic [NW*AW-1:0] wr_addr,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic             flush,
    output logic [DEPTH-1:0] busy,
    output logic [DEPTH-1:0] clr,
    output logic [AW:0]      busy_cnt
);
    logic [DEPTH-1:0] busy_nxt;
    logic [AW:0]      cnt_nxt;
    logic             rsv_ok;

    assign rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);

    always_comb begin
        clr = '0;
        for (int w = 0; w < NW; w++)
            if (wr_eff[w]) clr[wr_addr[w*AW +: AW]] = 1'b1;
    end

    // later steps override earlier ones: clear, then reserve, then flush
    always_comb begin
        busy_nxt = busy & ~clr;
        if (rsv_ok) busy_nxt[rsv_addr] = 1'b1;
        if (flush) busy_nxt = '0;
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end
endmodule

// File: rtl/regfile_sb_mp.sv
// regfile_sb_mp: multi-port write-through register file with optional zero register and busy scoreboard
module regfile_sb_mp import regfile_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int NR = DEF_NR,
    parameter int NW = DEF_NW,
    parameter int ZERO_REG = 1,
    localparam int AW = calc_aw(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NR*AW-1:0]    rd_addr,
    output logic [NR*WIDTH-1:0] rd_data,
    output logic [NR-1:0]       rd_busy,
    input  logic [NW-1:0]       wr_en,
    input  logic [NW*AW-1:0]    wr_addr,
    input  logic [NW*WIDTH-1:0] wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [NW-1:0]    wr_eff;
    logic [DEPTH-1:0] busy, clr;

    always_comb begin
        wr_eff = '0;
        for (int w = 0; w < NW; w++)
            wr_eff[w] = wr_en[w] && !(ZERO_REG != 0 && wr_addr[w*AW +: AW] == '0);
    end

    // ascending port order makes the highest-index writer win on collisions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int w = 0; w < NW; w++)
                if (wr_eff[w]) mem[wr_addr[w*AW +: AW]] <= wr_data[w*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int r = 0; r < NR; r++) begin
            rd_data[r*WIDTH +: WIDTH] = mem[rd_addr[r*AW +: AW]];
            for (int w = 0; w < NW; w++)
                if (wr_eff[w] && wr_addr[w*AW +: AW] == rd_addr[r*AW +: AW])
                    rd_data[r*WIDTH +: WIDTH] = wr_data[w*WIDTH +: WIDTH];
            if (!rst_n || (ZERO_REG != 0 && rd_addr[r*AW +: AW] == '0))
                rd_data[r*WIDTH +: WIDTH] = '0;
            rd_busy[r] = rst_n && busy[rd_addr[r*AW +: AW]] && !clr[rd_addr[r*AW +: AW]];
        end
    end

    regfile_scoreboard #(.DEPTH(DEPTH), .NW(NW), .ZERO_REG(ZERO_REG)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_eff   (wr_eff),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .busy     (busy),
        .clr      (clr),
        .busy_cnt (busy_cnt)
    );
endmodule

// File: tb/tb_regfile_sb_mp.sv
// tb_regfile_sb_mp: directed and random checks of regfile_sb_mp against an array-based reference model
module tb_regfile_sb_mp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en = '0;
    logic [9:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        rsv_en = 1'b0;
    logic [4:0]  rsv_addr = '0;
    logic        flush = 1'b0;
    logic [5:0]  busy_cnt;

    logic [4:0]  z_rd_addr = '0;
    logic [31:0] z_rd_data;
    logic [0:0]  z_rd_busy;
    logic [0:0]  z_wr_en = '0;
    logic [4:0]  z_wr_addr = '0;
    logic [31:0] z_wr_data = '0;
    logic        z_rsv_en = 1'b0;
    logic [4:0]  z_rsv_addr = '0;
    logic        z_flush = 1'b0;
    logic [5:0]  z_busy_cnt;

    int tests = 0;
    int fails = 0;
    logic [31:0] m_mem [32];
    bit          m_busy [32];

    always #5 clk = ~clk;

    regfile_sb_mp #(.WIDTH(32), .DEPTH(32), .NR(2), .NW(2), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .flush(flush), .busy_cnt(busy_cnt)
    );

    regfile_sb_mp #(.WIDTH(32), .DEPTH(32), .NR(1), .NW(1), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .rd_addr(z_rd_addr), .rd_data(z_rd_data), .rd_busy(z_rd_busy),
        .wr_en(z_wr_en), .wr_addr(z_wr_addr), .wr_data(z_wr_data), .rsv_en(z_rsv_en),
        .rsv_addr(z_rsv_addr), .flush(z_flush), .busy_cnt(z_busy_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_en = '0; rsv_en = 1'b0; flush = 1'b0;
        z_wr_en = '0; z_rsv_en = 1'b0; z_flush = 1'b0;
    endtask

    task automatic wr(input int w, input logic [4:0] a, input logic [31:0] d);
        wr_en[w] = 1'b1;
        wr_addr[w*5 +: 5] = a;
        wr_data[w*32 +: 32] = d;
    endtask

    task automatic rsv(input logic [4:0] a);
        rsv_en = 1'b1;
        rsv_addr = a;
    endtask

    task automatic rd(input int r, input logic [4:0] a);
        rd_addr[r*5 +: 5] = a;
    endtask

    function automatic bit writes(input int w, input logic [4:0] a);
        return wr_en[w] && wr_addr[w*5 +: 5] == a && a != 0;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        logic [31:0] v;
        if (a == 0) return 32'h0;
        v = m_mem[a];
        if (writes(0, a)) v = wr_data[31:0];
        if (writes(1, a)) v = wr_data[63:32];
        return v;
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        return a != 0 && m_busy[a] && !writes(0, a) && !writes(1, a);
    endfunction

    function automatic int count_busy();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic model_edge();
        for (int w = 0; w < 2; w++)
            if (writes(w, wr_addr[w*5 +: 5])) begin
                m_mem[wr_addr[w*5 +: 5]] = wr_data[w*32 +: 32];
                m_busy[wr_addr[w*5 +: 5]] = 1'b0;
            end
        if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
        if (flush) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // called just after a falling edge with inputs applied; returns at the next falling edge
    task automatic step(input string tag);
        #1;
        for (int r = 0; r < 2; r++) begin
            chk({tag, "_data"}, 64'(rd_data[r*32 +: 32]), 64'(exp_data(rd_addr[r*5 +: 5])));
            chk({tag, "_busy"}, 64'(rd_busy[r]), 64'(exp_busy(rd_addr[r*5 +: 5])));
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk({tag, "_cnt"}, 64'(busy_cnt), 64'(count_busy()));
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_cnt", 64'(busy_cnt), 64'd0);
        chk("rst_rd", 64'(rd_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        wr(0, 5'd3, 32'h1234_5678); rd(0, 5'd3); rd(1, 5'd3);
        #1 chk("wt_bypass", 64'(rd_data[31:0]), 64'h1234_5678);
        step("wt");
        idle();
        #1 chk("wt_stored", 64'(rd_data[31:0]), 64'h1234_5678);
        step("wt2");

        wr(0, 5'd9, 32'h11); wr(1, 5'd9, 32'h22); rd(0, 5'd9);
        #1 chk("coll_bypass", 64'(rd_data[31:0]), 64'h22);
        step("coll");
        idle();
        #1 chk("coll_stored", 64'(rd_data[31:0]), 64'h22);
        step("coll2");

        wr(0, 5'd0, 32'hFFFF_FFFF); rsv(5'd0); rd(0, 5'd0);
        z_wr_en = 1'b1; z_wr_addr = 5'd0; z_wr_data = 32'hFFFF_FFFF;
        z_rsv_en = 1'b1; z_rsv_addr = 5'd0; z_rd_addr = 5'd0;
        step("zero");
        idle();
        #1;
        chk("zero_rd", 64'(rd_data[31:0]), 64'd0);
        chk("zero_busy", 64'(rd_busy[0]), 64'd0);
        chk("zero_cnt", 64'(busy_cnt), 64'd0);
        chk("nz_rd", 64'(z_rd_data), 64'hFFFF_FFFF);
        chk("nz_busy", 64'(z_rd_busy), 64'd1);
        chk("nz_cnt", 64'(z_busy_cnt), 64'd1);
        step("zero2");

        rsv(5'd4); rd(0, 5'd4);
        step("sb_rsv");
        idle();
        #1 chk("sb_busy", 64'(rd_busy[0]), 64'd1);
        chk("sb_cnt1", 64'(busy_cnt), 64'd1);
        wr(1, 5'd4, 32'h44);
        #1 chk("sb_clr_bypass", 64'(rd_busy[0]), 64'd0);
        step("sb_wr");
        chk("sb_cnt0", 64'(busy_cnt), 64'd0);
        idle();
        rsv(5'd4); wr(0, 5'd4, 32'h55);
        step("sb_both");
        idle();
        #1 chk("sb_rsv_wins", 64'(rd_busy[0]), 64'd1);
        step("sb_both2");

        rsv(5'd1); step("fl_r1");
        rsv(5'd2); step("fl_r2");
        rsv(5'd3); step("fl_r3");
        idle();
        chk("fl_cnt3", 64'(busy_cnt), 64'd4);
        flush = 1'b1; rsv(5'd6); wr(0, 5'd2, 32'hAB); rd(0, 5'd6); rd(1, 5'd2);
        step("fl");
        idle();
        #1;
        chk("fl_cnt0", 64'(busy_cnt), 64'd0);
        chk("fl_r6", 64'(rd_busy[0]), 64'd0);
        chk("fl_r2", 64'(rd_data[63:32]), 64'hAB);
        step("fl2");

        wr(0, 5'd5, 32'hDEAD_BEEF); rsv(5'd7);
        step("mid");
        idle();
        rd(0, 5'd5); rd(1, 5'd7); wr(1, 5'd5, 32'h777);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rd", 64'(rd_data[31:0]), 64'd0);
        chk("mid_busy", 64'(rd_busy[1]), 64'd0);
        chk("mid_cnt", 64'(busy_cnt), 64'd0);
        chk("mid_nzcnt", 64'(z_busy_cnt), 64'd0);
        model_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1 chk("mid_after", 64'(rd_data[31:0]), 64'd0);
        step("mid2");

        for (int i = 0; i < 400; i++) begin
            idle();
            for (int w = 0; w < 2; w++)
                if ($urandom_range(0, 1) == 1) wr(w, 5'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 2) != 0) rsv(5'($urandom_range(0, 15)));
            flush = ($urandom_range(0, 15) == 0);
            rd(0, 5'($urandom_range(0, 7)));
            rd(1, 5'($urandom_range(0, 31)));
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
